// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared types, constants and helpers for the iterative multiply/divide unit
//
// Contents:
//   MDU_XLEN    - operand/result width
//   MDU_STEPS   - iterations per operation (one bit per BUSY cycle)
//   MDU_CNT_W   - width of the step counter
//   mdu_op_t    - MUL, DIV, DIVU, REM, REMU
//   mdu_state_t - control FSM states IDLE, BUSY, DONE
//   isDivOp / isSignedOp / isRemOp / absVal - operation classification and magnitude helpers

package mdu_ctrl_pkg;

  localparam int MDU_XLEN  = 64;
  localparam int MDU_STEPS = 64;
  localparam int MDU_CNT_W = $clog2(MDU_STEPS);

  typedef enum logic [2:0] {
    MDU_MUL  = 3'd0,
    MDU_DIV  = 3'd1,
    MDU_DIVU = 3'd2,
    MDU_REM  = 3'd3,
    MDU_REMU = 3'd4
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic isDivOp(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  function automatic logic isSignedOp(input mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic isRemOp(input mdu_op_t op);
    return (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  // Magnitude of v when treated as signed; the most negative value maps to
  // itself, which is the correct unsigned magnitude 2^63.
  function automatic logic [MDU_XLEN-1:0] absVal(input logic [MDU_XLEN-1:0] v, input logic sgn);
    return (sgn && v[MDU_XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational iteration of shift-add multiply / restoring divide
//
// Ports:
//   partial     in  running product (multiply) or partial remainder (divide)
//   operand     in  multiplicand (multiply) or divisor magnitude (divide)
//   isDiv       in  1 = divide iteration, 0 = multiply iteration
//   inBit       in  next multiplier bit (multiply) or next dividend bit (divide), MSB first
//   nextPartial out updated product / remainder
//   qBit        out quotient bit produced by this iteration (0 for multiply)

module mdu_step
  import mdu_ctrl_pkg::*;
(
  input  logic [MDU_XLEN-1:0] partial,
  input  logic [MDU_XLEN-1:0] operand,
  input  logic                isDiv,
  input  logic                inBit,
  output logic [MDU_XLEN-1:0] nextPartial,
  output logic                qBit
);

  // The shifted remainder needs one extra bit: with a divisor above 2^63 the
  // remainder shifted left can exceed 64 bits before the subtraction.
  logic [MDU_XLEN:0]   wide;
  logic [MDU_XLEN-1:0] diffLow;
  logic [MDU_XLEN-1:0] mulSum;

  always_comb begin
    wide    = {partial, inBit};
    // Only used when wide >= operand, so the true difference fits in 64 bits.
    diffLow = wide[MDU_XLEN-1:0] - operand;
    mulSum  = {partial[MDU_XLEN-2:0], 1'b0} + (inBit ? operand : '0);
    qBit    = isDiv && (wide >= {1'b0, operand});
    if (isDiv) begin
      nextPartial = qBit ? diffLow : wide[MDU_XLEN-1:0];
    end else begin
      nextPartial = mulSum;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative 64-bit multiply/divide controller, one bit per cycle
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   in_valid/in_ready     operation handshake (in_ready only in IDLE)
//   in_op, in_a, in_b     operation and operands, sampled only on accept
//   flush                 abandon any in-flight operation, back to IDLE
//   out_valid/out_ready   result handshake (out_valid only in DONE)
//   out_result            result, held stable while in DONE
//
// Build option MDU_EARLY_OUT_EN: divide by zero and signed overflow
// (min / -1) skip the iterations and go straight to DONE.

module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  mdu_op_t             in_op,
  input  logic [MDU_XLEN-1:0] in_a,
  input  logic [MDU_XLEN-1:0] in_b,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MDU_XLEN-1:0] out_result
);

  localparam logic [MDU_CNT_W-1:0] LAST_STEP = MDU_CNT_W'(MDU_STEPS - 1);
  localparam logic [MDU_XLEN-1:0]  MIN_INT   = {1'b1, {(MDU_XLEN-1){1'b0}}};

  mdu_state_t            state, nextState;
  logic                  accept;
  logic [MDU_CNT_W-1:0]  count;
  mdu_op_t               opReg;
  logic [MDU_XLEN-1:0]   partial;
  logic [MDU_XLEN-1:0]   shiftReg;   // multiplier bits out, quotient bits in
  logic [MDU_XLEN-1:0]   operand;
  logic                  negQuot;
  logic                  negRem;

  logic [MDU_XLEN-1:0]   stepPartial;
  logic                  stepQBit;
  logic [MDU_XLEN-1:0]   quot;
  logic [MDU_XLEN-1:0]   finalResult;

  logic                  earlyOut;
  logic [MDU_XLEN-1:0]   earlyResult;

`ifdef MDU_EARLY_OUT_EN
  logic divZero;
  logic divOvf;

  assign divZero  = (in_b == '0);
  assign divOvf   = isSignedOp(in_op) && (in_a == MIN_INT) && (in_b == '1);
  assign earlyOut = isDivOp(in_op) && (divZero || divOvf);

  always_comb begin
    earlyResult = '0;
    if (isRemOp(in_op)) begin
      earlyResult = divZero ? in_a : '0;
    end else begin
      earlyResult = divZero ? '1 : MIN_INT;
    end
  end
`else
  assign earlyOut    = 1'b0;
  assign earlyResult = '0;
`endif

  mdu_step uStep (
    .partial     (partial),
    .operand     (operand),
    .isDiv       (isDivOp(opReg)),
    .inBit       (shiftReg[MDU_XLEN-1]),
    .nextPartial (stepPartial),
    .qBit        (stepQBit)
  );

  // Result of the final iteration with sign correction applied.
  always_comb begin
    quot        = {shiftReg[MDU_XLEN-2:0], stepQBit};
    finalResult = stepPartial;
    if (isDivOp(opReg)) begin
      if (isRemOp(opReg)) begin
        finalResult = negRem ? -stepPartial : stepPartial;
      end else begin
        finalResult = negQuot ? -quot : quot;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    if (flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            accept    = 1'b1;
            nextState = earlyOut ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (count == LAST_STEP) begin
            nextState = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            nextState = IDLE;
          end
        end
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      opReg      <= MDU_MUL;
      partial    <= '0;
      shiftReg   <= '0;
      operand    <= '0;
      negQuot    <= 1'b0;
      negRem     <= 1'b0;
      out_result <= '0;
    end else if (accept) begin
      count   <= '0;
      opReg   <= in_op;
      partial <= '0;
      if (isDivOp(in_op)) begin
        shiftReg <= absVal(in_a, isSignedOp(in_op));
        operand  <= absVal(in_b, isSignedOp(in_op));
      end else begin
        shiftReg <= in_b;
        operand  <= in_a;
      end
      // A zero divisor keeps the all-ones quotient un-negated; the remainder
      // still follows the dividend's sign, which reproduces the dividend.
      negQuot <= isSignedOp(in_op) && (in_a[MDU_XLEN-1] ^ in_b[MDU_XLEN-1]) && (in_b != '0);
      negRem  <= isSignedOp(in_op) && in_a[MDU_XLEN-1];
      if (earlyOut) begin
        out_result <= earlyResult;
      end
    end else if ((state == BUSY) && !flush) begin
      count    <= count + 1'b1;
      partial  <= stepPartial;
      shiftReg <= quot;
      if (count == LAST_STEP) begin
        out_result <= finalResult;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
//
// Drives and samples on the falling clock edge. Set MDU_EARLY_OUT_EN to
// match the build of the design under test.

module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 65;
`endif
  localparam int FULL_LAT = 65;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  mdu_op_t     in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  int nTests = 0;
  int nFails = 0;

  mdu_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one operation at the current falling edge, measure latency to
  // out_valid, optionally stall the consumer, then release the result.
  task automatic runOp(input string tag, input mdu_op_t op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp,
                       input int expLat, input int hold);
    int cyc;
    checkVal({tag, " in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = MDU_MUL;
    in_a     = {$urandom, $urandom};
    in_b     = {$urandom, $urandom};
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkVal({tag, " latency"}, 64'(cyc), 64'(expLat));
    checkVal({tag, " result"}, out_result, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      checkVal({tag, " hold result"}, out_result, exp);
      checkVal({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
      checkVal({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
    end
    // Offer a new operation during the handover cycle; it must not be taken.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkVal({tag, " release out_valid"}, 64'(out_valid), 64'd0);
    checkVal({tag, " release in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = MDU_MUL;
    in_a      = '0;
    in_b      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkVal("reset out_valid", 64'(out_valid), 64'd0);
    checkVal("reset in_ready", 64'(in_ready), 64'd1);
    checkVal("reset out_result", out_result, 64'd0);

    runOp("mul 7x-3", MDU_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, FULL_LAT, 0);
    runOp("mul wide", MDU_MUL, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
          64'h0000_0002_0000_0001, FULL_LAT, 0);
    runOp("div -7/2", MDU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, FULL_LAT, 0);
    runOp("rem -7%2", MDU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, FULL_LAT, 0);
    runOp("divu 100/7", MDU_DIVU, 64'd100, 64'd7, 64'd14, FULL_LAT, 0);
    runOp("remu 100%7", MDU_REMU, 64'd100, 64'd7, 64'd2, FULL_LAT, 0);
    runOp("div 100/-7", MDU_DIV, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, FULL_LAT, 0);
    runOp("rem 100%-7", MDU_REM, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, FULL_LAT, 0);
    runOp("divu big", MDU_DIVU, ONES, 64'h8000_0000_0000_0001, 64'd1, FULL_LAT, 0);
    runOp("remu big", MDU_REMU, ONES, 64'h8000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFE, FULL_LAT, 0);
    runOp("divu 5/0", MDU_DIVU, 64'd5, 64'd0, ONES, EARLY_LAT, 0);
    runOp("remu 5%0", MDU_REMU, 64'd5, 64'd0, 64'd5, EARLY_LAT, 0);
    runOp("div -5/0", MDU_DIV, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, EARLY_LAT, 0);
    runOp("rem -5%0", MDU_REM, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, EARLY_LAT, 0);
    runOp("div min/-1", MDU_DIV, MINV, ONES, MINV, EARLY_LAT, 0);
    runOp("rem min%-1", MDU_REM, MINV, ONES, 64'd0, EARLY_LAT, 0);
    runOp("hold mul", MDU_MUL, 64'd123, 64'd1000, 64'd123000, FULL_LAT, 10);

    // Flush during BUSY cycle 30 with a new operation offered.
    in_valid = 1'b1;
    in_op    = MDU_DIVU;
    in_a     = 64'd100;
    in_b     = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_op    = MDU_MUL;
    in_a     = 64'd3;
    in_b     = 64'd4;
    checkVal("flush busy in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkVal("flush idle in_ready", 64'(in_ready), 64'd1);
    checkVal("flush out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkVal("flush no result", 64'(seen), 64'd0);

    // Flush in IDLE overrides a simultaneous offer.
    flush    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkVal("flush idle no accept", 64'(in_ready), 64'd1);
    runOp("after flush mul", MDU_MUL, 64'd3, 64'd4, 64'd12, FULL_LAT, 0);

    // Reset asserted between clock edges in the middle of BUSY.
    in_valid = 1'b1;
    in_op    = MDU_DIV;
    in_a     = 64'hFFFF_FFFF_FFFF_FFF9;
    in_b     = 64'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkVal("async reset out_valid", 64'(out_valid), 64'd0);
    checkVal("async reset in_ready", 64'(in_ready), 64'd1);
    checkVal("async reset out_result", out_result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    checkVal("post reset in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkVal("reset no stale result", 64'(seen), 64'd0);
    runOp("after reset divu", MDU_DIVU, 64'd1000, 64'd10, 64'd100, FULL_LAT, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; one clock, no other clock or reset.
REQ-003 SHALL have port in_valid, input, 1: an operation is offered.
REQ-004 SHALL have port in_ready, output, 1: the block can accept an operation.
REQ-005 SHALL have port in_op, input, mdu_op_t: MUL, DIV, DIVU, REM or REMU.
REQ-006 SHALL have ports in_a and in_b, input, 64 each: dividend/multiplicand and divisor/multiplier.
REQ-007 SHALL have port flush, input, 1: kill any in-flight operation.
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port out_result, output, 64: the result.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-012 SHALL accept when in_valid & in_ready & !flush; IDLE->BUSY, latch op and operands, step counter=0.
REQ-013 SHALL perform one iteration per BUSY cycle (shift-add multiply, restoring divide); after the step with counter=63, BUSY->DONE.
REQ-014 SHALL give fixed latency: accept in cycle 0, BUSY cycles 1..64, out_valid first high in cycle 65.
REQ-015 SHALL hold out_result stable and out_valid high in DONE until out_ready=1; DONE & out_ready -> IDLE next edge.
REQ-016 SHALL NOT accept in the DONE->IDLE handover cycle (in_ready=0 while in DONE).
REQ-017 SHALL return MUL as the low 64 bits of in_a*in_b; signedness irrelevant.
REQ-018 SHALL divide magnitudes for DIV/REM and sign-correct: quotient negated if signs differ, remainder takes dividend's sign.
REQ-019 SHALL return, for divisor 0: quotient 64'hFFFF_FFFF_FFFF_FFFF, remainder = dividend (signed and unsigned).
REQ-020 SHALL return, for DIV/REM of 64'h8000_0000_0000_0000 by -1: quotient 64'h8000_0000_0000_0000, remainder 0.
REQ-021 SHALL, when flush=1 in any state, go to IDLE next edge with out_valid=0; flush overrides a simultaneous in_valid and a simultaneous out_ready.
REQ-022 SHALL ignore in_op/in_a/in_b outside the accept cycle.

Reset
REQ-023 SHALL on reset assertion, immediately and regardless of clk, force state=IDLE, counter=0, out_valid=0, out_result=0, in_ready=1 (after reset release).
REQ-024 SHALL discard an operation interrupted by reset mid-BUSY or mid-DONE; no result is ever presented for it.

Configuration
REQ-025 SHALL, with MDU_EARLY_OUT_EN defined, detect divisor 0 or the signed-overflow case at accept and go IDLE->DONE directly, out_valid in cycle 1 with REQ-019/020 values.
REQ-026 SHALL, without MDU_EARLY_OUT_EN, run those cases through the full 64-step BUSY path with the same results, latency per REQ-014.

Structure
REQ-027 SHALL place mdu_op_t and constant MDU_STEPS=64 in the shared common package.
REQ-028 SHALL factor one iteration into combinational sub-module mdu_step (inputs: partial/remainder, operand, op class; outputs: next partial, next quotient bit); FSM, counter, sign handling stay in mdu_ctrl.

Verification
REQ-029 SHALL cover: MUL 7 x -3 (64'hFFFF_FFFF_FFFF_FFFD) -> out_result 64'hFFFF_FFFF_FFFF_FFEB, out_valid in cycle 65.
REQ-030 SHALL cover: DIV -7 / 2 -> 64'hFFFF_FFFF_FFFF_FFFD; REM -7 % 2 -> 64'hFFFF_FFFF_FFFF_FFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-031 SHALL cover: DIVU 5 / 0 -> all-ones, REMU -> 5; DIV 64'h8000_0000_0000_0000 / -1 -> 64'h8000_0000_0000_0000; latency 1 or 65 per macro.
REQ-032 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_result stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-033 SHALL cover: flush at BUSY cycle 30 with in_valid=1 -> IDLE, no out_valid, new operation not accepted that cycle, next accepted operation correct.
REQ-034 SHALL cover: reset asserted mid-BUSY between clock edges -> out_valid=0 and in_ready=1 immediately after release, no stale result.
